fetch_controller: RTL and testbench

//  Sequences the instruction-fetch stage: drives PC-register write enable, branch-target select and IF/ID enable/flush.

---
 rtl/fetch_controller.sv | 139 +++++++++++++
 tb/tb_fetch_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: PC/IF-ID enables, branch redirect, hazard hold and memory wait tracking.
// Optional FETCH_STALL_COUNT_EN adds a saturating stallCount output.
module fetch_controller #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_WAIT     = 15,
  parameter int CNT_WIDTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        brTaken,
  input  logic        hazardDetected,
  input  logic        memReady,
  output logic        memReq,
  output logic        pcWriteEn,
  output logic        pcSel,
  output logic        ifIdWriteEn,
  output logic        ifIdFlush,
`ifdef FETCH_STALL_COUNT_EN
  output logic [31:0] stallCount,
`endif
  output logic        fetchTimeout
);

  // state    | meaning
  // IDLE     | one-cycle bubble after reset, all outputs low
  // FETCH    | request outstanding, advance PC on memReady
  // HOLD     | load-use hazard, fetch paused at current PC
  // REDIRECT | IF/ID held flushed after a taken branch
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, REDIRECT} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] WAIT_MAX   = CNT_WIDTH'(MAX_WAIT);
  localparam logic [CNT_WIDTH-1:0] WAIT_LAST  = CNT_WIDTH'(MAX_WAIT - 1);
  localparam logic [CNT_WIDTH-1:0] FLUSH_LAST = CNT_WIDTH'(FLUSH_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   wait_q, wait_d;
  logic [CNT_WIDTH-1:0]   flush_q, flush_d;
  logic                   timeout_q, timeout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      flush_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      flush_q   <= flush_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    flush_d     = flush_q;
    timeout_d   = timeout_q;
    memReq      = 1'b0;
    pcWriteEn   = 1'b0;
    pcSel       = 1'b0;
    ifIdWriteEn = 1'b0;
    ifIdFlush   = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        memReq = 1'b1;
        if (brTaken) begin
          pcSel     = 1'b1;
          pcWriteEn = 1'b1;
          ifIdFlush = 1'b1;
          wait_d    = '0;
          flush_d   = '0;
          state_d   = REDIRECT;
        end else if (hazardDetected) begin
          state_d = HOLD;
        end else if (memReady) begin
          pcWriteEn   = 1'b1;
          ifIdWriteEn = 1'b1;
          wait_d      = '0;
        end else begin
          // Counter saturates at MAX_WAIT; the flag is set on the edge that reaches it.
          if (wait_q < WAIT_MAX) wait_d = wait_q + CNT_ONE;
          if (wait_q >= WAIT_LAST) timeout_d = 1'b1;
        end
      end

      HOLD: begin
        if (brTaken) begin
          pcSel     = 1'b1;
          pcWriteEn = 1'b1;
          ifIdFlush = 1'b1;
          wait_d    = '0;
          flush_d   = '0;
          state_d   = REDIRECT;
        end else if (!hazardDetected) begin
          wait_d  = '0;
          state_d = FETCH;
        end
      end

      REDIRECT: begin
        ifIdFlush = 1'b1;
        if (flush_q >= FLUSH_LAST) begin
          flush_d = '0;
          state_d = FETCH;
        end else begin
          flush_d = flush_q + CNT_ONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign fetchTimeout = timeout_q;

`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] stall_q;
  logic        stall_cycle;

  assign stall_cycle = (state_q == HOLD) || (state_q == REDIRECT) ||
                       ((state_q == FETCH) && !memReady);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (stall_cycle && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stallCount = stall_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios followed by random traffic
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_controller;

  localparam int FLUSH = 1;
  localparam int MAXW  = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic brTaken = 1'b0;
  logic hazardDetected = 1'b0;
  logic memReady = 1'b0;
  logic memReq, pcWriteEn, pcSel, ifIdWriteEn, ifIdFlush, fetchTimeout;
`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] stallCount;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Model: what the fetch stage is doing, in plain terms.
  bit      m_bubble;
  bit      m_holding;
  int      m_flush_left;
  int      m_waits;
  bit      m_timeout;
  longint  m_stall;

  always #5 clk = ~clk;

  fetch_controller #(.FLUSH_CYCLES(FLUSH), .MAX_WAIT(MAXW), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .brTaken(brTaken), .hazardDetected(hazardDetected),
    .memReady(memReady), .memReq(memReq), .pcWriteEn(pcWriteEn), .pcSel(pcSel),
    .ifIdWriteEn(ifIdWriteEn), .ifIdFlush(ifIdFlush),
`ifdef FETCH_STALL_COUNT_EN
    .stallCount(stallCount),
`endif
    .fetchTimeout(fetchTimeout)
  );

  function automatic logic [5:0] outs();
    return {memReq, pcWriteEn, pcSel, ifIdWriteEn, ifIdFlush, fetchTimeout};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bubble = 1; m_holding = 0; m_flush_left = 0;
    m_waits = 0; m_timeout = 0; m_stall = 0;
  endtask

  // Expected {memReq,pcWriteEn,pcSel,ifIdWriteEn,ifIdFlush,fetchTimeout} for this cycle, then advance.
  task automatic model_cycle(input bit br, input bit hz, input bit rdy, output logic [5:0] e);
    bit req = 0, pcwe = 0, sel = 0, ifwe = 0, fl = 0;
    e = {5'b0, m_timeout};
    if (m_bubble) begin
      m_bubble = 0;
    end else if (m_flush_left > 0) begin
      fl = 1; m_stall++; m_flush_left--;
    end else if (br) begin
      sel = 1; pcwe = 1; fl = 1; req = !m_holding;
      if (m_holding || !rdy) m_stall++;
      m_holding = 0; m_flush_left = FLUSH; m_waits = 0;
    end else if (m_holding) begin
      m_stall++;
      if (!hz) begin m_holding = 0; m_waits = 0; end
    end else begin
      req = 1;
      if (hz) begin
        m_holding = 1;
        if (!rdy) m_stall++;
      end else if (rdy) begin
        pcwe = 1; ifwe = 1; m_waits = 0;
      end else begin
        m_stall++;
        if (m_waits < MAXW) m_waits++;
        if (m_waits >= MAXW) m_timeout = 1;
      end
    end
    e = {req, pcwe, sel, ifwe, fl, e[0]};
  endtask

  task automatic step(input bit br, input bit hz, input bit rdy, input string tag);
    logic [5:0] e;
    @(negedge clk);
    brTaken = br; hazardDetected = hz; memReady = rdy;
    #2;
`ifdef FETCH_STALL_COUNT_EN
    chk({tag, "_stall"}, stallCount, m_stall[31:0]);
`endif
    model_cycle(br, hz, rdy, e);
    chk(tag, {26'b0, outs()}, {26'b0, e});
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1; brTaken = 0; hazardDetected = 0; memReady = 0;
    #1;
    chk({tag, "_outs"}, {26'b0, outs()}, 32'h0);
`ifdef FETCH_STALL_COUNT_EN
    chk({tag, "_stall"}, stallCount, 32'h0);
`endif
    @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    model_reset();

    do_reset("init_rst");

    // Ready tied high: bubble, then one fetch per cycle.
    step(0, 0, 1, "bubble");
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, "stream");
      cnt += int'(pcWriteEn) + int'(ifIdWriteEn);
    end
    chk("ten_fetches", cnt, 20);

    // Three wait states then ready.
    for (int i = 0; i < 3; i++) step(0, 0, 0, "wait3");
    step(0, 0, 1, "wait3_done");
    chk("wait3_no_timeout", {31'b0, fetchTimeout}, 32'h0);

    // Branch wins over hazard and ready in the same cycle.
    step(1, 1, 1, "br_prio");
    chk("br_prio_sel", {31'b0, pcSel}, 32'h1);
    step(0, 0, 1, "redirect");
    chk("redirect_flush", {31'b0, ifIdFlush}, 32'h1);
    step(0, 0, 1, "refetch");
    chk("refetch_req", {31'b0, memReq}, 32'h1);

    // Two hazard cycles, then resume.
    step(0, 1, 1, "haz1");
    step(0, 1, 1, "haz2");
    chk("haz2_noreq", {30'b0, memReq, pcWriteEn}, 32'h0);
    step(0, 0, 1, "haz_release");
    step(0, 0, 1, "haz_resume");

    // Long wait: timeout is sticky until reset.
    for (int i = 0; i < 20; i++) step(0, 0, 0, "long_wait");
    for (int i = 0; i < 3; i++) step(0, 0, 1, "after_wait");
    chk("timeout_sticky", {31'b0, fetchTimeout}, 32'h1);
    do_reset("timeout_rst");
    chk("timeout_cleared", {31'b0, fetchTimeout}, 32'h0);

    // Reset asserted while flushing after a branch.
    step(0, 0, 1, "pre_br_idle");
    step(0, 0, 0, "pre_br_fetch");
    step(1, 0, 0, "br_then_rst");
    do_reset("mid_redirect_rst");
    step(0, 0, 1, "post_rst_idle");
    step(0, 0, 1, "post_rst_fetch");

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rand_rst");
      end else begin
        step($urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 2) != 0, "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
